// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, command/response codes and parity helper
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        WAIT_FIRST,
        XFER,
        WAIT_IDLE,
        FAIL
    } state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    localparam logic [7:0] ACK    = 8'hFA;
    localparam logic [7:0] RESEND = 8'hFE;

    // data bits + parity + stop, as shifted out after the start bit
    localparam int unsigned BITS_PER_FRAME = 10;

    // PS/2 uses odd parity: the bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_command_tx_if.sv
// rtl/ps2_command_tx_if.sv - command request/status handshake between game logic and the PS/2 transmitter
//   send    : one-cycle request, accepted only when the transmitter is idle
//   command : byte to send, captured with an accepted send
//   busy    : transfer in progress
//   done    : one-cycle pulse, byte acknowledged by the device
//   error   : one-cycle pulse, timeout or missing acknowledge
interface ps2_command_tx_if;
    logic       send;
    logic [7:0] command;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output send,
        output command,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  send,
        input  command,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - two-flop synchronizer with falling-edge detect for one PS/2 line
//   clock, reset : system clock, synchronous active-high reset
//   raw          : asynchronous pin level
//   level        : synchronized level
//   fe           : one-cycle pulse on a synchronized high-to-low transition
module ps2_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fe
);

    logic meta;
    logic sync;
    logic prev;

    // An idle PS/2 line floats high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= raw;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fe    = prev & ~sync;

endmodule

// File: rtl/ps2_command_tx.sv
// rtl/ps2_command_tx.sv - host-to-device PS/2 command byte transmitter (open-drain via output enables)
//   clock, reset             : system clock, synchronous active-high reset
//   cmd                      : send/command request, busy/done/error status
//   ps2_clk_in, ps2_dat_in   : raw pin levels
//   ps2_clk_oe, ps2_dat_oe   : 1 pulls the line low, 0 releases it
module ps2_command_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 50_000_000,
    parameter int unsigned INHIBIT_CYCLES  = 6_000,
    parameter int unsigned START_TIMEOUT   = 750_000,
    parameter int unsigned PACKET_TIMEOUT  = 100_000
) (
    input  logic             clock,
    input  logic             reset,
    ps2_command_tx_if.slave  cmd,
    input  logic             ps2_clk_in,
    input  logic             ps2_dat_in,
    output logic             ps2_clk_oe,
    output logic             ps2_dat_oe
);

    // One timer serves every phase. Sized for the largest of one second of
    // clocks and the configured counts so any sane setting fits.
    localparam int unsigned MAX_AB   = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int unsigned MAX_ABC  = (MAX_AB > PACKET_TIMEOUT) ? MAX_AB : PACKET_TIMEOUT;
    localparam int unsigned MAX_ALL  = (MAX_ABC > CLOCK_FREQUENCY) ? MAX_ABC : CLOCK_FREQUENCY;
    localparam int unsigned TIMER_W  = $clog2(MAX_ALL + 1);

    localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] PACKET_LAST  = TIMER_W'(PACKET_TIMEOUT - 1);
    localparam logic [3:0]         LAST_BIT     = 4'(BITS_PER_FRAME);

    logic clk_level;
    logic clk_fe;
    logic dat_level;
    logic unused_dat_fe;

    ps2_line_sync u_clk_sync (
        .clock (clock),
        .reset (reset),
        .raw   (ps2_clk_in),
        .level (clk_level),
        .fe    (clk_fe)
    );

    ps2_line_sync u_dat_sync (
        .clock (clock),
        .reset (reset),
        .raw   (ps2_dat_in),
        .level (dat_level),
        .fe    (unused_dat_fe)
    );

    state_t                 state,     state_n;
    logic [TIMER_W-1:0]     timer,     timer_n;
    logic [3:0]             bitcnt,    bitcnt_n;
    logic [9:0]             shift,     shift_n;
    logic                   dat_drive, dat_drive_n;
    logic                   done_q,    done_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            bitcnt    <= '0;
            shift     <= '0;
            dat_drive <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            bitcnt    <= bitcnt_n;
            shift     <= shift_n;
            dat_drive <= dat_drive_n;
            done_q    <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        timer_n     = timer + 1'b1;
        bitcnt_n    = bitcnt;
        shift_n     = shift;
        dat_drive_n = dat_drive;
        done_n      = 1'b0;

        case (state)
            IDLE: begin
                timer_n     = '0;
                dat_drive_n = 1'b0;
                if (cmd.send) begin
                    shift_n  = {1'b1, odd_parity(cmd.command), cmd.command};
                    bitcnt_n = '0;
                    state_n  = INHIBIT;
                end
            end

            INHIBIT: begin
                if (timer == INHIBIT_LAST) begin
                    timer_n = '0;
                    state_n = REQ;
                end
            end

            REQ: begin
                timer_n = '0;
                state_n = WAIT_FIRST;
            end

            WAIT_FIRST: begin
                if (clk_fe) begin
                    // The device latches the start bit on this edge; put data bit 0 out.
                    dat_drive_n = ~shift[0];
                    shift_n     = {1'b1, shift[9:1]};
                    bitcnt_n    = 4'd1;
                    timer_n     = '0;
                    state_n     = XFER;
                end else if (timer == START_LAST) begin
                    state_n = FAIL;
                end
            end

            XFER: begin
                if (clk_fe) begin
                    if (bitcnt == LAST_BIT) begin
                        // Edge after the stop bit: the device must be holding data low.
                        dat_drive_n = 1'b0;
                        state_n     = dat_level ? FAIL : WAIT_IDLE;
                    end else begin
                        dat_drive_n = ~shift[0];
                        shift_n     = {1'b1, shift[9:1]};
                        bitcnt_n    = bitcnt + 4'd1;
                    end
                end else if (timer == PACKET_LAST) begin
                    state_n = FAIL;
                end
            end

            WAIT_IDLE: begin
                dat_drive_n = 1'b0;
                if (clk_level && dat_level) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (timer == PACKET_LAST) begin
                    state_n = FAIL;
                end
            end

            FAIL: begin
                dat_drive_n = 1'b0;
                state_n     = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign ps2_clk_oe = (state == INHIBIT) || (state == REQ);
    assign ps2_dat_oe = (state == REQ) || (state == WAIT_FIRST) || ((state == XFER) && dat_drive);

    // done is registered, so busy drops in the same cycle the pulse appears;
    // FAIL is likewise excluded so error and busy-low coincide.
    assign cmd.busy  = (state != IDLE) && (state != FAIL);
    assign cmd.done  = done_q;
    assign cmd.error = (state == FAIL);

endmodule

// File: tb/tb_ps2_command_tx.sv
// tb/tb_ps2_command_tx.sv - scoreboard bench for ps2_command_tx with a behavioural PS/2 device
module tb_ps2_command_tx;
    import ps2_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ps2_command_tx_if bus();

    logic ps2_clk_oe, ps2_dat_oe;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    wire  clk_line = ~(ps2_clk_oe | dev_clk_low);
    wire  dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_command_tx #(
        .CLOCK_FREQUENCY (50_000_000),
        .INHIBIT_CYCLES  (20),
        .START_TIMEOUT   (500),
        .PACKET_TIMEOUT  (2000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd        (bus),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    typedef struct {
        bit         ok;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int done_count = 0;
    int exp_done_count = 0;
    int dev_edges = 0;
    logic [10:0] slots = '0;
    logic busy_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: odd parity means the frame's ones count (data + parity) is odd.
    function automatic logic model_parity(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // Monitor: every done/error pulse is matched against the oldest expectation.
    always @(negedge clock) begin
        if (!reset && (bus.done || bus.error)) begin
            exp_t e;
            if (bus.done) done_count++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse actual done=%0d error=%0d required none", bus.done, bus.error);
            end else begin
                e = sb.pop_front();
                check("outcome_done",  32'(bus.done),  32'(e.ok));
                check("outcome_error", 32'(bus.error), 32'(!e.ok));
                check("busy_low_at_pulse", 32'(bus.busy), 32'd0);
                check("busy_high_before_pulse", 32'(busy_prev), 32'd1);
                if (e.ok && bus.done) begin
                    check("start_bit", 32'(slots[0]), 32'd0);
                    check("data_byte", 32'(slots[8:1]), 32'(e.data));
                    check("parity_bit", 32'(slots[9]), 32'(model_parity(e.data)));
                    check("stop_bit", 32'(slots[10]), 32'd1);
                end
            end
        end
        busy_prev = bus.busy;
    end

    // Device: waits for the host request, then produces n_edges falling edges
    // with a 40-cycle clock, sampling data mid-high-phase before each edge.
    task automatic device_run(input int n_edges, input bit ack);
        int w = 0;
        dev_edges = 0;
        slots = '0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && w < 400) begin
            @(negedge clock);
            w++;
        end
        if (w >= 400) begin
            total++;
            bad++;
            $display("FAIL device_request_wait actual=timeout required=request");
            return;
        end
        repeat (10) @(negedge clock);
        for (int e = 1; e <= n_edges; e++) begin
            repeat (10) @(negedge clock);
            if (e <= 11) slots[e-1] = dat_line;
            if (e == 11) dev_dat_low = ack;
            repeat (10) @(negedge clock);
            dev_clk_low = 1'b1;
            dev_edges++;
            repeat (20) @(negedge clock);
            dev_clk_low = 1'b0;
        end
        repeat (10) @(negedge clock);
        dev_dat_low = 1'b0;
        repeat (10) @(negedge clock);
    endtask

    task automatic send_cmd(input logic [7:0] c, input bit push, input bit ok);
        exp_t e;
        @(negedge clock);
        bus.command = c;
        bus.send = 1'b1;
        if (push) begin
            e.ok = ok;
            e.data = c;
            sb.push_back(e);
            if (ok) exp_done_count++;
        end
        @(negedge clock);
        bus.send = 1'b0;
    endtask

    task automatic drain(input string name);
        int w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clock);
            w++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic normal_xfer(input logic [7:0] c);
        fork
            device_run(11, 1'b1);
            send_cmd(c, 1'b1, 1'b1);
        join
        drain("drain_normal");
    endtask

    initial begin
        logic [7:0] rc;
        int w;
        int k;
        bus.send = 1'b0;
        bus.command = 8'h00;

        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("reset_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("reset_busy",   32'(bus.busy),   32'd0);
        check("reset_done",   32'(bus.done),   32'd0);
        check("reset_error",  32'(bus.error),  32'd0);

        normal_xfer(CMD_SET_LEDS);
        normal_xfer(CMD_ENABLE);
        normal_xfer(8'h00);

        // Device never clocks: error must come START_TIMEOUT cycles after WAIT_FIRST entry.
        send_cmd(CMD_RESET, 1'b1, 1'b0);
        w = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && w < 200) begin
            @(negedge clock);
            w++;
        end
        check("wait_first_seen", 32'(w < 200), 32'd1);
        k = 0;
        while (!bus.error && k < 1000) begin
            @(negedge clock);
            k++;
        end
        check("start_timeout_cycles", 32'(k), 32'd500);
        @(negedge clock);
        check("after_error_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("after_error_dat_oe", 32'(ps2_dat_oe), 32'd0);
        drain("drain_timeout");

        // Missing acknowledge on the 11th edge.
        fork
            device_run(11, 1'b0);
            send_cmd(8'h5A, 1'b1, 1'b0);
        join
        drain("drain_nack");

        // Reset in the middle of the data phase.
        fork
            device_run(5, 1'b1);
            begin
                send_cmd(8'hA5, 1'b0, 1'b0);
                w = 0;
                while (dev_edges < 4 && w < 1000) begin
                    @(negedge clock);
                    w++;
                end
                check("reach_fourth_edge", 32'(w < 1000), 32'd1);
                repeat (25) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                check("midreset_clk_oe", 32'(ps2_clk_oe), 32'd0);
                check("midreset_dat_oe", 32'(ps2_dat_oe), 32'd0);
                check("midreset_busy",   32'(bus.busy),   32'd0);
                reset = 1'b0;
            end
        join
        repeat (50) @(negedge clock);
        normal_xfer(CMD_RESET);

        // Second send during INHIBIT is ignored.
        fork
            device_run(11, 1'b1);
            begin
                send_cmd(8'h3C, 1'b1, 1'b1);
                repeat (5) @(negedge clock);
                send_cmd(8'h12, 1'b0, 1'b0);
            end
        join
        drain("drain_ignored_send");

        for (int i = 0; i < 4; i++) begin
            rc = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 30)) @(negedge clock);
            normal_xfer(rc);
        end

        repeat (50) @(negedge clock);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("done_count", 32'(done_count), 32'(exp_done_count));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
